// File: rtl/arm_regfile_sb.sv
// ---------------------------------------------------------------------------
// arm_regfile_sb
//   Multi-read-port register file with a per-register pending-write
//   scoreboard. ID reads operands through rd_addr/rd_data and uses rd_busy to
//   stall on RAW hazards; issue logic marks destinations pending with
//   issue_en/issue_dest; WB writes results and retires one pending count.
//
//   Optional feature macro: REGFILE_FWD_EN
//     defined   - a same-cycle write-back to a read address is forwarded to
//                 rd_data, and rd_busy is cleared when that write-back
//                 retires the last outstanding count.
//     undefined - reads see stored state only; rd_busy is purely registered.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   rd_addr     NUM_RD x 4-bit read addresses (port p at [4p+3:4p])
//   rd_data     NUM_RD x DATA_W read data (port p at [DATA_W*p +: DATA_W])
//   rd_busy     per-port: addressed register has an outstanding write
//   wb_en       write-back enable
//   wb_addr     write-back destination
//   wb_data     write-back value
//   issue_en    an issued instruction will write issue_dest
//   issue_dest  destination being marked pending
//   issue_full  pending counter of issue_dest is saturated; issue not counted
//   pend_map    bit i set while register i has outstanding writes
//
// Addresses >= NUM_REGS are outside the file: reads return 0 and not busy,
// writes and issues to them are ignored.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module arm_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15,
    parameter int NUM_RD   = 2,
    parameter int PEND_W   = 2,
    parameter int INIT_IDX = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*4-1:0]      rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wb_en,
    input  logic [3:0]               wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     issue_en,
    input  logic [3:0]               issue_dest,
    output logic                     issue_full,
    output logic [NUM_REGS-1:0]      pend_map
);

    localparam logic [PEND_W-1:0] CNT_MAX    = '1;
    localparam logic [PEND_W-1:0] CNT_ONE    = PEND_W'(1);
    localparam logic [4:0]        NUM_REGS_L = 5'(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [PEND_W-1:0] cnt_q  [NUM_REGS];
    logic [PEND_W-1:0] cnt_d  [NUM_REGS];

    logic                wb_valid;
    logic                issue_valid;
    logic                issue_acc;
    logic [PEND_W-1:0]   issue_cnt;
    logic [NUM_REGS-1:0] wb_sel;    // one-hot: register written this cycle
    logic [NUM_REGS-1:0] iss_sel;   // one-hot: register accepting an issue

    // Decode write-back and issue requests against the implemented registers.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so
        // no path leaves it unassigned, which would infer a latch.
        wb_sel      = '0;
        iss_sel     = '0;
        issue_cnt   = '0;
        wb_valid    = wb_en && ({1'b0, wb_addr} < NUM_REGS_L);
        issue_valid = issue_en && ({1'b0, issue_dest} < NUM_REGS_L);
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_dest == 4'(i)) begin
                issue_cnt = cnt_q[i];
            end
        end
        // A saturated counter refuses the issue; the issuer re-presents it.
        issue_full = issue_valid && (issue_cnt == CNT_MAX);
        issue_acc  = issue_valid && !issue_full;
        for (int i = 0; i < NUM_REGS; i++) begin
            wb_sel[i]  = wb_valid  && (wb_addr    == 4'(i));
            iss_sel[i] = issue_acc && (issue_dest == 4'(i));
        end
    end

    // Next-state: data write plus pending-counter bookkeeping.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            cnt_d[i]  = cnt_q[i];
            if (wb_sel[i]) begin
                regs_d[i] = wb_data;
            end
            // Issue and write-back on the same register cancel out.
            if (iss_sel[i] && !wb_sel[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (wb_sel[i] && !iss_sel[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    // Read ports and hazard flags.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr[4*p +: 4] == 4'(i)) begin
                    rd_data[DATA_W*p +: DATA_W] = regs_q[i];
                    rd_busy[p]                  = (cnt_q[i] != '0);
`ifdef REGFILE_FWD_EN
                    if (wb_sel[i]) begin
                        rd_data[DATA_W*p +: DATA_W] = wb_data;
                        // This write-back retires the last outstanding write.
                        if ((cnt_q[i] == CNT_ONE) && !iss_sel[i]) begin
                            rd_busy[p] = 1'b0;
                        end
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_map[i] = (cnt_q[i] != '0);
        end
    end

    // NOTE: the register array itself is reset because the architecture
    // defines its power-on contents (index value or zero), not just the
    // scoreboard counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: state is updated with non-blocking assignments so every
                // flop samples the values from before this edge.
                regs_q[i] <= (INIT_IDX != 0) ? DATA_W'(i) : '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_arm_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_arm_regfile_sb
//   Self-checking bench for arm_regfile_sb with default parameters. Directed
//   scenarios followed by random traffic; every cycle the outputs are compared
//   against an array-based reference model of the register file and its
//   pending-write counts.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_arm_regfile_sb;

    localparam int NR   = 15;
    localparam int PMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ra0, ra1;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        issue_en;
    logic [3:0]  issue_dest;
    logic        issue_full;
    logic [14:0] pend_map;

    assign rd_addr = {ra1, ra0};

    arm_regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .issue_en   (issue_en),
        .issue_dest (issue_dest),
        .issue_full (issue_full),
        .pend_map   (pend_map)
    );

    always #5 clk = ~clk;

    int    total  = 0;
    int    passed = 0;
    int    failed = 0;
    string phase  = "init";

    // Reference model: architectural contents and outstanding-write counts.
    logic [31:0] m_reg [16];
    int          m_cnt [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i] = (i < NR) ? 32'(i) : 32'h0;
            m_cnt[i] = 0;
        end
    endfunction

    function automatic bit issue_taken();
        return issue_en && (issue_dest < NR) && (m_cnt[issue_dest] < PMAX);
    endfunction

    function automatic logic [31:0] exp_data(input logic [3:0] a);
        if (a >= NR) return 32'h0;
`ifdef REGFILE_FWD_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a);
        if (a >= NR) return 1'b0;
`ifdef REGFILE_FWD_EN
        if (wb_en && wb_addr == a && m_cnt[a] == 1 && !(issue_taken() && issue_dest == a))
            return 1'b0;
`endif
        return m_cnt[a] != 0;
    endfunction

    function automatic logic [14:0] exp_pend();
        logic [14:0] m;
        for (int i = 0; i < NR; i++) m[i] = (m_cnt[i] != 0);
        return m;
    endfunction

    // Compare all outputs mid-cycle, away from the rising edge.
    task automatic sample();
        @(negedge clk);
        check("rd0",   rd_data[31:0],        exp_data(ra0));
        check("rd1",   rd_data[63:32],       exp_data(ra1));
        check("busy0", 32'(rd_busy[0]),      32'(exp_busy(ra0)));
        check("busy1", 32'(rd_busy[1]),      32'(exp_busy(ra1)));
        check("full",  32'(issue_full),
              32'(issue_en && issue_dest < NR && m_cnt[issue_dest] == PMAX));
        check("pend",  32'(pend_map),        32'(exp_pend()));
    endtask

    // Advance one edge, then apply the same inputs to the model.
    task automatic tick();
        bit inc, wbv;
        @(posedge clk);
        #1;
        inc = issue_taken();
        wbv = wb_en && (wb_addr < NR);
        if (wbv) m_reg[wb_addr] = wb_data;
        if (!(inc && wbv && wb_addr == issue_dest)) begin
            if (wbv && m_cnt[wb_addr] > 0) m_cnt[wb_addr] = m_cnt[wb_addr] - 1;
            if (inc) m_cnt[issue_dest] = m_cnt[issue_dest] + 1;
        end
    endtask

    task automatic idle();
        wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'h0;
        issue_en = 1'b0; issue_dest = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ra0 = 4'd0; ra1 = 4'd1;
        idle();
        model_reset();

        // Reset state
        phase = "reset";
        #12;
        check("rd0_in_reset", rd_data[31:0], 32'h0);
        check("rd1_in_reset", rd_data[63:32], 32'h1);
        check("pend_in_reset", 32'(pend_map), 32'h0);
        @(posedge clk); #1; rst = 1'b0;

        // 1: every address reads its index, nothing pending
        phase = "t1";
        for (int a = 0; a < NR; a++) begin
            ra0 = 4'(a); ra1 = 4'(NR - 1 - a);
            sample();
            check("idx0", rd_data[31:0], 32'(a));
            check("idx1", rd_data[63:32], 32'(NR - 1 - a));
            tick();
        end

        // 2: write r3, same-cycle and next-cycle read
        phase = "t2";
        ra0 = 4'd3; ra1 = 4'd4;
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEADBEEF;
        sample();
`ifdef REGFILE_FWD_EN
        check("same_cycle", rd_data[31:0], 32'hDEADBEEF);
`else
        check("same_cycle", rd_data[31:0], 32'h3);
`endif
        tick();
        idle();
        sample();
        check("next_cycle", rd_data[31:0], 32'hDEADBEEF);
        tick();

        // 3: saturate r5, then drain it
        phase = "t3";
        ra0 = 4'd5;
        issue_en = 1'b1; issue_dest = 4'd5;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("not_full", 32'(issue_full), 32'h0);
            tick();
        end
        sample();
        check("full", 32'(issue_full), 32'h1);
        check("pend5", 32'(pend_map[5]), 32'h1);
        tick();
        idle();
        wb_en = 1'b1; wb_addr = 4'd5;
        for (int k = 1; k <= 3; k++) begin
            wb_data = 32'h500 + 32'(k);
            sample();
`ifdef REGFILE_FWD_EN
            check("busy_drain", 32'(rd_busy[0]), (k < 3) ? 32'h1 : 32'h0);
`else
            check("busy_drain", 32'(rd_busy[0]), 32'h1);
`endif
            tick();
        end
        idle();
        sample();
        check("busy_clear", 32'(rd_busy[0]), 32'h0);
        check("pend5_clear", 32'(pend_map[5]), 32'h0);
        tick();

        // 4: issue and write-back to r7 in the same cycle
        phase = "t4";
        ra0 = 4'd7;
        issue_en = 1'b1; issue_dest = 4'd7;
        sample(); tick();
        wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h77777777;
        sample(); tick();
        idle();
        sample();
        check("r7_data", rd_data[31:0], 32'h77777777);
        check("r7_pend", 32'(pend_map[7]), 32'h1);
        tick();

        // 5: write to unimplemented address 15
        phase = "t5";
        ra0 = 4'd15; ra1 = 4'd3;
        wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'h1234;
        sample();
        check("r15_same", rd_data[31:0], 32'h0);
        tick();
        idle();
        sample();
        check("r15_after", rd_data[31:0], 32'h0);
        check("r3_kept", rd_data[63:32], 32'hDEADBEEF);
        tick();

        // 6: asynchronous reset with r2 pending and holding 0x55
        phase = "t6";
        ra0 = 4'd2; ra1 = 4'd7;
        issue_en = 1'b1; issue_dest = 4'd2;
        sample(); tick();
        sample(); tick();
        idle();
        wb_en = 1'b1; wb_addr = 4'd2; wb_data = 32'h55;
        sample(); tick();
        idle();
        sample();
        check("r2_pre", rd_data[31:0], 32'h55);
        check("pend_pre", 32'(pend_map != 15'h0), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("r2_reset", rd_data[31:0], 32'h2);
        check("pend_reset", 32'(pend_map), 32'h0);
        check("busy_reset", 32'(rd_busy), 32'h0);
        model_reset();
        @(posedge clk); #1; rst = 1'b0;
        sample(); tick();

        // Random traffic against the model
        phase = "rand";
        for (int n = 0; n < 600; n++) begin
            ra0        = 4'($urandom_range(0, 15));
            ra1        = 4'($urandom_range(0, 15));
            wb_en      = 1'($urandom_range(0, 1));
            wb_addr    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(4, 6));
            wb_data    = $urandom;
            issue_en   = 1'($urandom_range(0, 1));
            issue_dest = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(4, 6));
            if ($urandom_range(0, 3) == 0) ra0 = issue_dest;
            if ($urandom_range(0, 3) == 0) ra1 = wb_addr;
            sample();
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
